// File: rtl/kbd_uart_pkg.sv
// kbd_uart_pkg: shared constants, FSM state type and sizing helper for the keyboard-to-UART bridge
package kbd_uart_pkg;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE} state_t;
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; a pop frees room for a same-cycle push when full
module sync_fifo
   import kbd_uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
)(
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [WIDTH-1:0]          i_data,
   output logic [WIDTH-1:0]          o_data,
   output logic                      o_full,
   output logic                      o_empty,
   output logic [cnt_w(DEPTH)-1:0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;
   assign o_empty = r_count == '0;
   assign o_full  = r_count == FULL_CNT;
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_data  = r_mem[r_rd];
   assign o_count = r_count;
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr] <= i_data;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         r_wr    <= w_push ? r_wr + AW'(1) : r_wr;
         r_rd    <= w_pop ? r_rd + AW'(1) : r_rd;
         r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end
endmodule

// File: rtl/kbd_uart_bridge.sv
// kbd_uart_bridge: buffers keyboard ASCII bytes and paces them into the UART parallel TX port,
// optionally expanding CR into CR LF
module kbd_uart_bridge
   import kbd_uart_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int BUSY_TIMEOUT = 64,
   parameter int CRLF_EXPAND  = 1
)(
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [7:0]                i_kbd_data,
   input  logic                      i_kbd_data_valid,
   output logic [7:0]                o_tx_data,
   output logic                      o_tx_data_valid,
   input  logic                      i_tx_busy,
   input  logic                      i_clr_overflow,
   output logic                      o_overflow,
   output logic                      o_tx_timeout,
   output logic [cnt_w(DEPTH)-1:0]   o_fifo_count,
   output logic                      o_idle
);
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   state_t          r_state;
   state_t          w_state_nxt;
   logic [TW-1:0]   r_tmr;
   logic [TW-1:0]   w_tmr_nxt;
   logic            r_lf;
   logic            w_lf_nxt;
   logic [7:0]      r_tx_data;
   logic [7:0]      w_tx_data_nxt;
   logic            r_tx_valid;
   logic            w_launch;
   logic            w_pop;
   logic            w_to_set;
   logic            w_ovf_set;
   logic            w_full;
   logic            w_empty;
   logic [7:0]      w_head;
   logic            r_ovf;
   logic            r_to;

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (i_kbd_data_valid),
      .i_pop   (w_pop),
      .i_data  (i_kbd_data),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_fifo_count)
   );

   // A pending LF always goes out before the next FIFO byte so CR LF stays adjacent
   always_comb begin
      w_state_nxt   = r_state;
      w_tmr_nxt     = r_tmr;
      w_lf_nxt      = r_lf;
      w_tx_data_nxt = r_tx_data;
      w_launch      = 1'b0;
      w_pop         = 1'b0;
      w_to_set      = 1'b0;
      case (r_state)
         IDLE:
            if (!i_tx_busy && r_lf) begin
               w_tx_data_nxt = ASCII_LF;
               w_launch      = 1'b1;
               w_lf_nxt      = 1'b0;
               w_tmr_nxt     = TW'(1);
               w_state_nxt   = WAIT_START;
            end else if (!i_tx_busy && !w_empty) begin
               w_pop         = 1'b1;
               w_tx_data_nxt = w_head;
               w_launch      = 1'b1;
               w_lf_nxt      = (CRLF_EXPAND != 0) && (w_head == ASCII_CR);
               w_tmr_nxt     = TW'(1);
               w_state_nxt   = WAIT_START;
            end
         WAIT_START:
            if (i_tx_busy) begin
               w_state_nxt = WAIT_DONE;
            end else if (r_tmr == TW'(BUSY_TIMEOUT)) begin
               w_to_set    = 1'b1;
               w_lf_nxt    = 1'b0;
               w_state_nxt = IDLE;
            end else begin
               w_tmr_nxt = r_tmr + TW'(1);
            end
         WAIT_DONE:
            w_state_nxt = i_tx_busy ? WAIT_DONE : IDLE;
         default:
            w_state_nxt = IDLE;
      endcase
   end

   assign w_ovf_set = i_kbd_data_valid & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_tmr      <= '0;
         r_lf       <= 1'b0;
         r_tx_data  <= 8'h00;
         r_tx_valid <= 1'b0;
         r_ovf      <= 1'b0;
         r_to       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tmr      <= w_tmr_nxt;
         r_lf       <= w_lf_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_tx_valid <= w_launch;
         r_ovf      <= w_ovf_set | (r_ovf & ~i_clr_overflow);
         r_to       <= w_to_set | (r_to & ~i_clr_overflow);
      end
   end

   assign o_tx_data       = r_tx_data;
   assign o_tx_data_valid = r_tx_valid;
   assign o_overflow      = r_ovf;
   assign o_tx_timeout    = r_to;
   assign o_idle          = (o_fifo_count == '0) & (r_state == IDLE) & ~r_lf;
endmodule

// File: tb/tb_kbd_uart_bridge.sv
// tb_kbd_uart_bridge: directed and randomized checks of the bridge against a queue-based launch model
module tb_kbd_uart_bridge;
   localparam int BD = 3;
   localparam int BH = 20;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic [7:0] kbd_data = 8'h00;
   logic kbd_valid = 1'b0;
   logic kbd_valid1 = 1'b0;
   logic clr = 1'b0;
   logic force_busy = 1'b0;
   logic b_en = 1'b1;
   logic resp_busy0 = 1'b0;
   logic resp_busy1 = 1'b0;
   logic busy0, busy1;
   logic [7:0] tx_data0, tx_data1;
   logic tx_valid0, tx_valid1, ovf0, ovf1, to0, to1, idle0, idle1;
   logic [4:0] count0, count1;
   int checks = 0;
   int errors = 0;
   int bc0 = -1;
   int bc1 = -1;
   logic [7:0] got0[$], got1[$], exp0[$], exp1[$];

   assign busy0 = force_busy | resp_busy0;
   assign busy1 = resp_busy1;

   kbd_uart_bridge #(.DEPTH(16), .BUSY_TIMEOUT(64), .CRLF_EXPAND(1)) dut0 (
      .clk(clk), .resetn(resetn), .i_kbd_data(kbd_data), .i_kbd_data_valid(kbd_valid),
      .o_tx_data(tx_data0), .o_tx_data_valid(tx_valid0), .i_tx_busy(busy0),
      .i_clr_overflow(clr), .o_overflow(ovf0), .o_tx_timeout(to0),
      .o_fifo_count(count0), .o_idle(idle0));

   kbd_uart_bridge #(.DEPTH(16), .BUSY_TIMEOUT(64), .CRLF_EXPAND(0)) dut1 (
      .clk(clk), .resetn(resetn), .i_kbd_data(kbd_data), .i_kbd_data_valid(kbd_valid1),
      .o_tx_data(tx_data1), .o_tx_data_valid(tx_valid1), .i_tx_busy(busy1),
      .i_clr_overflow(clr), .o_overflow(ovf1), .o_tx_timeout(to1),
      .o_fifo_count(count1), .o_idle(idle1));

   always #5 clk = ~clk;

   // UART stand-in: busy rises a few cycles after each strobe and stays high for a while
   always @(negedge clk) begin
      if (!resetn) begin
         resp_busy0 = 1'b0;
         bc0 = -1;
      end else begin
         if (tx_valid0 && b_en) bc0 = 0;
         else if (bc0 >= 0) bc0++;
         resp_busy0 = (bc0 >= BD) && (bc0 < BD + BH);
         if (bc0 >= BD + BH) bc0 = -1;
         if (tx_valid0) got0.push_back(tx_data0);
      end
   end

   always @(negedge clk) begin
      if (!resetn) begin
         resp_busy1 = 1'b0;
         bc1 = -1;
      end else begin
         if (tx_valid1) bc1 = 0;
         else if (bc1 >= 0) bc1++;
         resp_busy1 = (bc1 >= BD) && (bc1 < BD + BH);
         if (bc1 >= BD + BH) bc1 = -1;
         if (tx_valid1) got1.push_back(tx_data1);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic push(input logic [7:0] b, input logic both);
      kbd_data = b;
      kbd_valid = 1'b1;
      kbd_valid1 = both;
      tick;
      kbd_valid = 1'b0;
      kbd_valid1 = 1'b0;
   endtask

   task automatic expect0(input logic [7:0] b);
      exp0.push_back(b);
      if (b == 8'h0D) exp0.push_back(8'h0A);
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      while (!(idle0 && idle1) && n < lim) begin
         tick;
         n++;
      end
      chk("idle_reached", {30'd0, idle0, idle1}, 32'd3);
   endtask

   task automatic cmp_q(input string tag, input logic [7:0] g[$], input logic [7:0] e[$]);
      chk({tag, "_len"}, g.size(), e.size());
      for (int i = 0; i < g.size() && i < e.size(); i++)
         chk($sformatf("%s_%0d", tag, i), {24'd0, g[i]}, {24'd0, e[i]});
   endtask

   initial begin
      int n;
      logic [7:0] b;
      resetn = 1'b0;
      tick;
      tick;
      chk("rst_data", tx_data0, 8'h00);
      chk("rst_valid", tx_valid0, 1'b0);
      chk("rst_ovf", ovf0, 1'b0);
      chk("rst_to", to0, 1'b0);
      chk("rst_count", count0, 5'd0);
      chk("rst_idle", {idle0, idle1}, 2'b11);
      resetn = 1'b1;
      tick;

      kbd_data = 8'h41;
      kbd_valid = 1'b1;
      tick;
      kbd_valid = 1'b0;
      chk("lat_count1", count0, 5'd1);
      chk("lat_valid_early", tx_valid0, 1'b0);
      tick;
      chk("lat_valid", tx_valid0, 1'b1);
      chk("lat_data", tx_data0, 8'h41);
      chk("lat_count0", count0, 5'd0);
      tick;
      chk("single_strobe_width", tx_valid0, 1'b0);
      expect0(8'h41);
      wait_idle(200);
      chk("idle_busy_low", busy0, 1'b0);
      cmp_q("single", got0, exp0);
      got0.delete();
      exp0.delete();

      b_en = 1'b0;
      push(8'h55, 1'b0);
      push(8'h66, 1'b0);
      chk("to_launch_valid", tx_valid0, 1'b1);
      chk("to_launch_data", tx_data0, 8'h55);
      chk("to_count", count0, 5'd1);
      repeat (63) tick;
      chk("to_not_yet", to0, 1'b0);
      tick;
      chk("to_set", to0, 1'b1);
      tick;
      chk("to_next_valid", tx_valid0, 1'b1);
      chk("to_next_data", tx_data0, 8'h66);
      expect0(8'h55);
      expect0(8'h66);
      wait_idle(200);
      chk("to_sticky", to0, 1'b1);
      clr = 1'b1;
      tick;
      clr = 1'b0;
      chk("to_cleared", to0, 1'b0);
      b_en = 1'b1;
      cmp_q("timeout", got0, exp0);
      got0.delete();
      exp0.delete();

      force_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         push(8'(8'h30 + i), 1'b0);
         expect0(8'(8'h30 + i));
      end
      chk("burst_full", count0, 5'd16);
      chk("burst_no_ovf", ovf0, 1'b0);
      chk("burst_held", tx_valid0, 1'b0);
      push(8'h40, 1'b0);
      chk("ovf_set", ovf0, 1'b1);
      chk("ovf_count", count0, 5'd16);
      clr = 1'b1;
      tick;
      clr = 1'b0;
      chk("ovf_clr", ovf0, 1'b0);
      kbd_data = 8'h99;
      kbd_valid = 1'b1;
      clr = 1'b1;
      tick;
      kbd_valid = 1'b0;
      clr = 1'b0;
      chk("ovf_set_wins", ovf0, 1'b1);
      chk("ovf_count2", count0, 5'd16);
      clr = 1'b1;
      tick;
      clr = 1'b0;
      chk("ovf_clr2", ovf0, 1'b0);
      force_busy = 1'b0;
      push(8'h7A, 1'b0);
      expect0(8'h7A);
      chk("pushpop_count", count0, 5'd16);
      chk("pushpop_ovf", ovf0, 1'b0);
      chk("pushpop_valid", tx_valid0, 1'b1);
      chk("pushpop_data", tx_data0, 8'h30);
      wait_idle(2000);
      chk("burst_end_ovf", ovf0, 1'b0);
      cmp_q("burst", got0, exp0);
      got0.delete();
      exp0.delete();

      push(8'h0D, 1'b1);
      push(8'h42, 1'b1);
      exp0 = '{8'h0D, 8'h0A, 8'h42};
      exp1 = '{8'h0D, 8'h42};
      wait_idle(500);
      cmp_q("crlf_on", got0, exp0);
      cmp_q("crlf_off", got1, exp1);
      got0.delete();
      exp0.delete();

      repeat (2) begin
         for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) tick;
            b = 8'($urandom_range(0, 255));
            push(b, 1'b0);
            expect0(b);
         end
         wait_idle(3000);
         chk("rand_ovf", ovf0, 1'b0);
         cmp_q("rand", got0, exp0);
         got0.delete();
         exp0.delete();
      end

      for (int i = 0; i < 6; i++) push(8'(8'h10 + i), 1'b0);
      n = 0;
      while (!busy0 && n < 50) begin
         tick;
         n++;
      end
      chk("mid_busy_seen", busy0, 1'b1);
      tick;
      tick;
      chk("mid_queued", count0, 5'd5);
      resetn = 1'b0;
      tick;
      resetn = 1'b1;
      chk("mid_rst_count", count0, 5'd0);
      chk("mid_rst_valid", tx_valid0, 1'b0);
      chk("mid_rst_idle", idle0, 1'b1);
      chk("mid_rst_data", tx_data0, 8'h00);
      got0.delete();
      repeat (100) tick;
      chk("mid_no_launch", got0.size(), 0);
      chk("mid_still_idle", idle0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
